// File: rtl/aud_sram_arbiter.sv
// Audio SRAM arbiter: shares one 1M x 16 SRAM between recorder writes and player reads,
// driving CE/OE/WE/DQ timing from a registered access FSM with a forced turnaround idle cycle.
module aud_sram_arbiter #(
  parameter int unsigned RD_CYC       = 2,
  parameter int unsigned WR_CYC       = 2,
  parameter int unsigned MAX_WR_BURST = 4
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_wr_req,
  input  logic [19:0] i_wr_addr,
  input  logic [15:0] i_wr_data,
  output logic        o_wr_ack,
  input  logic        i_rd_req,
  input  logic [19:0] i_rd_addr,
  output logic [15:0] o_rd_data,
  output logic        o_rd_valid,
  input  logic        i_clr_end,
  output logic [19:0] o_end_addr,
  output logic        o_busy,
  output logic [19:0] o_sram_addr,
  output logic [15:0] o_sram_dq,
  output logic        o_sram_dq_oe,
  input  logic [15:0] i_sram_dq,
  output logic        o_sram_ce_n,
  output logic        o_sram_oe_n,
  output logic        o_sram_we_n,
  output logic        o_sram_lb_n,
  output logic        o_sram_ub_n
);

  localparam int unsigned MaxCyc  = (RD_CYC > WR_CYC) ? RD_CYC : WR_CYC;
  localparam int unsigned CntW    = $clog2(MaxCyc + 1);
  localparam int unsigned StreakW = $clog2(MAX_WR_BURST + 1);

  localparam logic [CntW-1:0]    RdLast   = CntW'(RD_CYC - 1);
  localparam logic [CntW-1:0]    WrLast   = CntW'(WR_CYC - 1);
  localparam logic [CntW-1:0]    CntOne   = CntW'(1);
  localparam logic [StreakW-1:0] MaxBurst = StreakW'(MAX_WR_BURST);
  localparam logic [StreakW-1:0] StrOne   = StreakW'(1);

  typedef enum logic [1:0] {StIdle, StRead, StWrite} state_e;

  state_e              state_q, state_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [StreakW-1:0]  streak_q, streak_d;
  logic [19:0]         addr_q, addr_d;
  logic [15:0]         wdata_q, wdata_d;
  logic [15:0]         rd_data_q, rd_data_d;
  logic                rd_valid_q, rd_valid_d;
  logic                wr_ack_q, wr_ack_d;
  logic [19:0]         end_addr_q, end_addr_d;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    streak_d   = streak_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
    wr_ack_d   = 1'b0;
    end_addr_d = end_addr_q;

    unique case (state_q)
      StIdle: begin
        // Writes win unless a read has waited through MAX_WR_BURST write grants.
        if (i_wr_req && (!i_rd_req || (streak_q < MaxBurst))) begin
          state_d  = StWrite;
          cnt_d    = '0;
          addr_d   = i_wr_addr;
          wdata_d  = i_wr_data;
          streak_d = i_rd_req ? (streak_q + StrOne) : '0;
        end else if (i_rd_req) begin
          state_d  = StRead;
          cnt_d    = '0;
          addr_d   = i_rd_addr;
          streak_d = '0;
        end
      end
      StWrite: begin
        if (cnt_q == WrLast) begin
          state_d    = StIdle;
          cnt_d      = '0;
          wr_ack_d   = 1'b1;
          end_addr_d = addr_q;
        end else begin
          cnt_d = cnt_q + CntOne;
        end
      end
      StRead: begin
        if (cnt_q == RdLast) begin
          state_d    = StIdle;
          cnt_d      = '0;
          rd_data_d  = i_sram_dq;
          rd_valid_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CntOne;
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase

    if (i_clr_end) begin
      end_addr_d = '0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      streak_q   <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      wr_ack_q   <= 1'b0;
      end_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      streak_q   <= streak_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      wr_ack_q   <= wr_ack_d;
      end_addr_q <= end_addr_d;
    end
  end

  // Pins decode registered state only; no request input reaches them combinationally.
  assign o_sram_ce_n  = (state_q == StIdle);
  assign o_sram_oe_n  = (state_q != StRead);
  assign o_sram_we_n  = (state_q != StWrite);
  assign o_sram_lb_n  = (state_q == StIdle);
  assign o_sram_ub_n  = (state_q == StIdle);
  assign o_sram_dq_oe = (state_q == StWrite);
  assign o_sram_addr  = addr_q;
  assign o_sram_dq    = wdata_q;

  assign o_busy     = (state_q != StIdle);
  assign o_wr_ack   = wr_ack_q;
  assign o_rd_valid = rd_valid_q;
  assign o_rd_data  = rd_data_q;
  assign o_end_addr = end_addr_q;

endmodule

// File: tb/tb_aud_sram_arbiter.sv
// Self-checking bench for aud_sram_arbiter: table of single accesses, then burst fairness,
// reset abort, end-address clear priority and a random protocol scoreboard.
module tb_aud_sram_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_req, rd_req, clr_end;
  logic [19:0] wr_addr, rd_addr;
  logic [15:0] wr_data;
  logic        wr_ack, rd_valid, busy;
  logic [15:0] rd_data;
  logic [19:0] end_addr, sram_addr;
  logic [15:0] sram_dq, sram_dq_in;
  logic        dq_oe, ce_n, oe_n, we_n, lb_n, ub_n;

  always #5 clk = ~clk;

  aud_sram_arbiter #(
    .RD_CYC      (2),
    .WR_CYC      (2),
    .MAX_WR_BURST(4)
  ) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_wr_req    (wr_req),
    .i_wr_addr   (wr_addr),
    .i_wr_data   (wr_data),
    .o_wr_ack    (wr_ack),
    .i_rd_req    (rd_req),
    .i_rd_addr   (rd_addr),
    .o_rd_data   (rd_data),
    .o_rd_valid  (rd_valid),
    .i_clr_end   (clr_end),
    .o_end_addr  (end_addr),
    .o_busy      (busy),
    .o_sram_addr (sram_addr),
    .o_sram_dq   (sram_dq),
    .o_sram_dq_oe(dq_oe),
    .i_sram_dq   (sram_dq_in),
    .o_sram_ce_n (ce_n),
    .o_sram_oe_n (oe_n),
    .o_sram_we_n (we_n),
    .o_sram_lb_n (lb_n),
    .o_sram_ub_n (ub_n)
  );

  // Small SRAM model indexed by the low address byte, with a preload port.
  logic [15:0] mem [256];
  logic        pl_en;
  logic [7:0]  pl_addr;
  logic [15:0] pl_data;

  always @(posedge clk) begin
    if (pl_en) mem[pl_addr] <= pl_data;
    else if (!ce_n && !we_n) mem[sram_addr[7:0]] <= sram_dq;
  end
  assign sram_dq_in = (!ce_n && !oe_n) ? mem[sram_addr[7:0]] : 16'h0000;

  // Bus protocol monitor.
  int   viol_ow = 0, viol_ta = 0, viol_pulse = 0;
  logic prev_oe_low = 1'b0, prev_dq_oe = 1'b0;

  always @(negedge clk) begin
    if (!oe_n && !we_n) viol_ow <= viol_ow + 1;
    if ((dq_oe && (!oe_n || prev_oe_low)) || (prev_dq_oe && !oe_n)) viol_ta <= viol_ta + 1;
    if (wr_ack && rd_valid) viol_pulse <= viol_pulse + 1;
    prev_oe_low <= !oe_n;
    prev_dq_oe  <= dq_oe;
  end

  int checks = 0, failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One access from an idle DUT; returns latency, strobe-low count and any pin-pattern error.
  task automatic do_access(input bit wr, input logic [19:0] a, input logic [15:0] d,
                           output int lat, output int low, output bit bad);
    lat = -1;
    low = 0;
    bad = 1'b0;
    if (wr) begin
      wr_req = 1'b1; wr_addr = a; wr_data = d;
    end else begin
      rd_req = 1'b1; rd_addr = a;
    end
    for (int n = 1; n <= 20 && lat < 0; n++) begin
      tick();
      if (wr && !we_n) begin
        low++;
        bad |= ce_n || !oe_n || !dq_oe || lb_n || ub_n || (sram_addr !== a) || (sram_dq !== d);
      end
      if (!wr && !oe_n) begin
        low++;
        bad |= ce_n || !we_n || dq_oe || lb_n || ub_n || (sram_addr !== a);
      end
      if (wr ? wr_ack : rd_valid) begin
        lat    = n;
        wr_req = 1'b0;
        rd_req = 1'b0;
      end
    end
    wr_req = 1'b0;
    rd_req = 1'b0;
  endtask

  typedef struct {
    bit          wr;
    logic [19:0] addr;
    logic [15:0] data;
    logic [15:0] exp_rd;
    logic [19:0] exp_end;
  } vec_t;

  vec_t        vecs [8];
  logic [15:0] shadow [16];

  initial begin
    int          lat, low;
    bit          bad;
    int          ncomp, first_valid, both;
    logic [9:0]  order;
    int          seen_ack;
    int          n_wr, n_rd, rd_wait, max_rd_wait;

    vecs[0] = '{1'b0, 20'h00010, 16'h0000, 16'hBEEF, 20'h00000};
    vecs[1] = '{1'b1, 20'hFFFFF, 16'h1234, 16'hBEEF, 20'hFFFFF};
    vecs[2] = '{1'b0, 20'hFFFFF, 16'h0000, 16'h1234, 20'hFFFFF};
    vecs[3] = '{1'b1, 20'h00020, 16'hCAFE, 16'h1234, 20'h00020};
    vecs[4] = '{1'b0, 20'h00020, 16'h0000, 16'hCAFE, 20'h00020};
    vecs[5] = '{1'b0, 20'h00010, 16'h0000, 16'hBEEF, 20'h00020};
    vecs[6] = '{1'b1, 20'h00001, 16'h5A5A, 16'hBEEF, 20'h00001};
    vecs[7] = '{1'b0, 20'h00001, 16'h0000, 16'h5A5A, 20'h00001};

    rst = 1'b1; wr_req = 1'b0; rd_req = 1'b0; clr_end = 1'b0;
    wr_addr = '0; rd_addr = '0; wr_data = '0;
    pl_en = 1'b1; pl_addr = 8'h10; pl_data = 16'hBEEF;
    tick();
    pl_en = 1'b0;
    tick();
    tick();
    check("reset_strobes_n", 32'({ce_n, oe_n, we_n, lb_n, ub_n}), 32'h1F);
    check("reset_dq_oe", 32'(dq_oe), 32'h0);
    check("reset_ack_valid", 32'({wr_ack, rd_valid}), 32'h0);
    check("reset_rd_data", 32'(rd_data), 32'h0);
    check("reset_end_addr", 32'(end_addr), 32'h0);
    check("reset_busy", 32'(busy), 32'h0);
    rst = 1'b0;

    for (int i = 0; i < 8; i++) begin
      do_access(vecs[i].wr, vecs[i].addr, vecs[i].data, lat, low, bad);
      check($sformatf("vec%0d_latency", i), 32'(lat), 32'd3);
      check($sformatf("vec%0d_strobe_low_cycles", i), 32'(low), 32'd2);
      check($sformatf("vec%0d_pin_pattern", i), 32'(bad), 32'h0);
      check($sformatf("vec%0d_rd_data", i), 32'(rd_data), 32'(vecs[i].exp_rd));
      check($sformatf("vec%0d_end_addr", i), 32'(end_addr), 32'(vecs[i].exp_end));
    end

    // Both requests held: expect W,W,W,W,R,W,W,W,W,R with the first read at cycle 15.
    wr_req = 1'b1; wr_addr = 20'h00030; wr_data = 16'h3030;
    rd_req = 1'b1; rd_addr = 20'h00010;
    ncomp = 0; first_valid = -1; both = 0; order = '0;
    for (int n = 1; n <= 60 && ncomp < 10; n++) begin
      tick();
      if (wr_ack && rd_valid) both++;
      if (wr_ack || rd_valid) begin
        order = {order[8:0], wr_ack};
        ncomp++;
      end
      if (rd_valid && first_valid < 0) first_valid = n;
    end
    wr_req = 1'b0; rd_req = 1'b0;
    check("burst_completions", 32'(ncomp), 32'd10);
    check("burst_grant_order", 32'(order), 32'(10'b1111011110));
    check("burst_double_pulse", 32'(both), 32'd0);
    check("burst_read_latency", 32'(first_valid), 32'd15);
    check("burst_rd_data", 32'(rd_data), 32'hBEEF);
    check("burst_end_addr", 32'(end_addr), 32'h00030);

    // Reset during the second write cycle aborts the access.
    wr_req = 1'b1; wr_addr = 20'h00300; wr_data = 16'h7777;
    tick();
    tick();
    check("abort_in_write", 32'(we_n), 32'h0);
    rst = 1'b1; wr_req = 1'b0;
    tick();
    check("abort_strobes_n", 32'({ce_n, oe_n, we_n, lb_n, ub_n}), 32'h1F);
    check("abort_dq_oe", 32'(dq_oe), 32'h0);
    check("abort_ack", 32'(wr_ack), 32'h0);
    check("abort_end_addr", 32'(end_addr), 32'h0);
    check("abort_rd_data", 32'(rd_data), 32'h0);
    rst = 1'b0;
    seen_ack = 0;
    for (int n = 0; n < 5; n++) begin
      tick();
      if (wr_ack || busy) seen_ack++;
    end
    check("abort_no_late_ack", 32'(seen_ack), 32'h0);

    // Clear-end in the completing cycle beats the end-address update.
    do_access(1'b1, 20'h00200, 16'h0001, lat, low, bad);
    check("pre_clr_end_addr", 32'(end_addr), 32'h00200);
    wr_req = 1'b1; wr_addr = 20'h00100; wr_data = 16'h0002;
    tick();
    tick();
    clr_end = 1'b1;
    tick();
    check("clr_ack", 32'(wr_ack), 32'h1);
    check("clr_end_addr_ack_cycle", 32'(end_addr), 32'h0);
    clr_end = 1'b0; wr_req = 1'b0;
    tick();
    check("clr_end_addr_after", 32'(end_addr), 32'h0);

    // Random streams over 16 addresses, with a known initial image.
    for (int i = 0; i < 16; i++) begin
      shadow[i] = 16'($urandom);
      do_access(1'b1, 20'h00040 | 20'(i), shadow[i], lat, low, bad);
    end
    n_wr = 0; n_rd = 0; rd_wait = 0; max_rd_wait = 0;
    for (int c = 0; c < 3000; c++) begin
      tick();
      if (wr_req && wr_ack) begin
        shadow[wr_addr[3:0]] = wr_data;
        wr_req = 1'b0;
        n_wr++;
      end else if (!wr_req && $urandom_range(3) == 0) begin
        wr_req  = 1'b1;
        wr_addr = 20'h00040 | 20'($urandom_range(15));
        wr_data = 16'($urandom);
      end
      if (rd_req) rd_wait++;
      if (rd_req && rd_valid) begin
        check("rand_rd_data", 32'(rd_data), 32'(shadow[rd_addr[3:0]]));
        if (rd_wait > max_rd_wait) max_rd_wait = rd_wait;
        rd_req = 1'b0;
        n_rd++;
      end else if (!rd_req && $urandom_range(3) == 0) begin
        rd_req  = 1'b1;
        rd_addr = 20'h00040 | 20'($urandom_range(15));
        rd_wait = 0;
      end
    end
    wr_req = 1'b0; rd_req = 1'b0;
    for (int n = 0; n < 10; n++) tick();
    check("rand_enough_writes", 32'(n_wr > 100), 32'h1);
    check("rand_enough_reads", 32'(n_rd > 100), 32'h1);
    check("rand_read_wait_bound", 32'(max_rd_wait <= 17), 32'h1);
    check("oe_we_overlap", 32'(viol_ow), 32'h0);
    check("dq_turnaround", 32'(viol_ta), 32'h0);
    check("ack_valid_same_cycle", 32'(viol_pulse), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
